mem_arbiter2: RTL

MEM_ARBITER2 -- requirements
Module: mem_arbiter2

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr.sv | 22 ++
 rtl/mem_arbiter2.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory-bus arbiter.
//   arb_state_e  : FSM state encoding (StTout exists only with MEM_ARB_TIMEOUT_EN)
//   TimeoutFill  : read data returned to a requester whose transfer timed out
//   TimeoutDflt  : default slave-response cycle limit
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    StTout = 2'd3
`endif
  } arb_state_e;

  localparam logic [31:0] TimeoutFill = 32'hDEAD_BEEF;
  localparam int unsigned TimeoutDflt = 255;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin pick between two requesters.
// Ports:
//   req        : request vector, bit n = requester n
//   last_grant : index of the requester granted most recently
//   grant_idx  : index to grant (only meaningful when |req)
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    if (&req) begin
      // Tie: the requester not served last wins.
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-requester memory-bus arbiter with round-robin fairness.
// One requester at a time is connected combinationally to the shared slave
// bus; every grant is followed by at least one idle cycle.
// Optional feature: define MEM_ARB_TIMEOUT_EN to force completion of a grant
// after TIMEOUT_CYCLES cycles without s_ready (reply 32'hDEAD_BEEF, pulse
// timeout_err). Without it timeout_err is tied 0 and a grant waits forever.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   mN_valid/instr/addr/wdata/wstrb : requester N request (N = 0, 1)
//   mN_ready, mN_rdata     : requester N response
//   s_valid/instr/addr/wdata/wstrb  : shared slave request
//   s_ready, s_rdata       : shared slave response
//   timeout_err            : one-cycle pulse on forced completion
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDflt
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mem_arbiter2: TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       rr_grant;
  logic       gnt_idx;
  logic       gnt_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        tout_idx_q, tout_idx_d;
`endif

  mem_arb_rr u_rr (
    .req        ({m1_valid, m0_valid}),
    .last_grant (last_grant_q),
    .grant_idx  (rr_grant)
  );

  // Index and request of the currently granted requester (valid in GNTn only).
  assign gnt_idx   = (state_q == StGnt1);
  assign gnt_valid = gnt_idx ? m1_valid : m0_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      tout_idx_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      tout_idx_q   <= tout_idx_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    tout_idx_d   = tout_idx_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (m0_valid || m1_valid) begin
          state_d = rr_grant ? StGnt1 : StGnt0;
        end
      end
      StGnt0, StGnt1: begin
        if (!gnt_valid) begin
          // Requester withdrew mid-transfer: abort without crediting it.
          state_d = StIdle;
        end else if (s_ready) begin
          state_d      = StIdle;
          last_grant_d = gnt_idx;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d      = StTout;
          tout_idx_d   = gnt_idx;
          last_grant_d = gnt_idx;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; everything is held at 0 while reset is asserted.
  always_comb begin
    s_valid     = 1'b0;
    s_instr     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    timeout_err = 1'b0;
    if (!reset) begin
      case (state_q)
        StGnt0: begin
          s_valid  = m0_valid;
          s_instr  = m0_instr;
          s_addr   = m0_addr;
          s_wdata  = m0_wdata;
          s_wstrb  = m0_wstrb;
          m0_ready = s_ready;
          m0_rdata = s_rdata;
        end
        StGnt1: begin
          s_valid  = m1_valid;
          s_instr  = m1_instr;
          s_addr   = m1_addr;
          s_wdata  = m1_wdata;
          s_wstrb  = m1_wstrb;
          m1_ready = s_ready;
          m1_rdata = s_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        StTout: begin
          timeout_err = 1'b1;
          if (tout_idx_q) begin
            m1_ready = 1'b1;
            m1_rdata = TimeoutFill;
          end else begin
            m0_ready = 1'b1;
            m0_rdata = TimeoutFill;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
